// File: rtl/fp_align_pipe.sv
// Two-stage FP add/sub pre-alignment: unpack/order operands, then shift the smaller mantissa with sticky.
// Optional build macro FP_ALIGN_DAZ_EN flushes subnormal inputs to signed zero before comparison.
module fp_align_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a_i,
  input  logic [EXP_W+MAN_W:0]   b_i,
  input  logic                   sub_i,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   s_big_o,
  output logic                   s_small_o,
  output logic                   swap_o,
  output logic                   eq_o,
  output logic                   special_o,
  output logic [EXP_W-1:0]       exp_o,
  output logic [MAN_W+4:0]       ma_o,
  output logic [MAN_W+4:0]       mb_o
);

  localparam int W  = EXP_W + MAN_W + 1;
  localparam int MW = MAN_W + 5;

  logic s1_adv, s2_adv;

  // Unpacked operand fields
  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb, ea_eff, eb_eff;
  logic [MAN_W-1:0] fa, fb;
  logic             b_gt, mag_eq, special_in;
  logic [MAN_W:0]   man_a, man_b;

  // Stage 1 registers
  logic             s1_valid;
  logic             s1_sbig, s1_ssmall, s1_swap, s1_eq, s1_special;
  logic [EXP_W-1:0] s1_exp, s1_d;
  logic [MAN_W:0]   s1_man_big, s1_man_small;

  // Stage 2 combinational results
  logic [MW-1:0]    small_full, shifted, lost_mask;
  logic             sticky;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  assign sa = a_i[W-1];
  assign sb = b_i[W-1] ^ sub_i;
  assign ea = a_i[W-2:MAN_W];
  assign eb = b_i[W-2:MAN_W];

`ifdef FP_ALIGN_DAZ_EN
  // Subnormals become signed zero; the sign bit is left untouched.
  assign fa = (ea == '0) ? '0 : a_i[MAN_W-1:0];
  assign fb = (eb == '0) ? '0 : b_i[MAN_W-1:0];
`else
  assign fa = a_i[MAN_W-1:0];
  assign fb = b_i[MAN_W-1:0];
`endif

  assign ea_eff     = (ea == '0) ? EXP_W'(1) : ea;
  assign eb_eff     = (eb == '0) ? EXP_W'(1) : eb;
  assign man_a      = {(ea != '0), fa};
  assign man_b      = {(eb != '0), fb};
  assign b_gt       = {eb, fb} > {ea, fa};
  assign mag_eq     = {eb, fb} == {ea, fa};
  assign special_in = (&ea) || (&eb);

  // Stage 1: order the operands by magnitude, ties keep A as the larger one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid     <= 1'b0;
      s1_sbig      <= 1'b0;
      s1_ssmall    <= 1'b0;
      s1_swap      <= 1'b0;
      s1_eq        <= 1'b0;
      s1_special   <= 1'b0;
      s1_exp       <= '0;
      s1_d         <= '0;
      s1_man_big   <= '0;
      s1_man_small <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_swap      <= b_gt;
        s1_eq        <= mag_eq;
        s1_special   <= special_in;
        s1_sbig      <= b_gt ? sb : sa;
        s1_ssmall    <= b_gt ? sa : sb;
        s1_exp       <= b_gt ? eb_eff : ea_eff;
        s1_d         <= b_gt ? (eb_eff - ea_eff) : (ea_eff - eb_eff);
        s1_man_big   <= b_gt ? man_b : man_a;
        s1_man_small <= b_gt ? man_a : man_b;
      end
    end
  end

  // Shifts past MW-1 naturally collapse to a lone sticky bit: shifted is 0 and the mask covers everything.
  assign small_full = {1'b0, s1_man_small, 3'b000};
  assign shifted    = small_full >> s1_d;
  assign lost_mask  = ~({MW{1'b1}} << s1_d);
  assign sticky     = |(small_full & lost_mask);

  // Stage 2: output register, held while downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      s_big_o   <= 1'b0;
      s_small_o <= 1'b0;
      swap_o    <= 1'b0;
      eq_o      <= 1'b0;
      special_o <= 1'b0;
      exp_o     <= '0;
      ma_o      <= '0;
      mb_o      <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        s_big_o   <= s1_sbig;
        s_small_o <= s1_ssmall;
        swap_o    <= s1_swap;
        eq_o      <= s1_eq;
        special_o <= s1_special;
        if (s1_special) begin
          exp_o <= '1;
          ma_o  <= '0;
          mb_o  <= '0;
        end else begin
          exp_o <= s1_exp;
          ma_o  <= {1'b0, s1_man_big, 3'b000};
          mb_o  <= shifted | {{(MW-1){1'b0}}, sticky};
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_align_pipe.sv
// Directed self-checking bench for fp_align_pipe (default single-precision parameters).
module tb_fp_align_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic        sub_i = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        s_big_o, s_small_o, swap_o, eq_o, special_o;
  logic [7:0]  exp_o;
  logic [27:0] ma_o, mb_o;

  int checks = 0;
  int failures = 0;

  // Snapshot of the most recent result captured by run_op
  int          r_cycles;
  logic        r_sbig, r_ssmall, r_swap, r_eq, r_special;
  logic [7:0]  r_exp;
  logic [27:0] r_ma, r_mb;

  fp_align_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_i(a_i), .b_i(b_i), .sub_i(sub_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .s_big_o(s_big_o), .s_small_o(s_small_o), .swap_o(swap_o), .eq_o(eq_o),
    .special_o(special_o), .exp_o(exp_o), .ma_o(ma_o), .mb_o(mb_o)
  );

  always #5 clk = ~clk;

  // Issue one op into an idle pipe and wait (bounded) for its result.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sub);
    out_ready = 1'b1;
    a_i = a; b_i = b; sub_i = sub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    r_cycles = 0;
    while (!out_valid && r_cycles < 10) begin
      @(posedge clk); #1;
      r_cycles++;
    end
    r_sbig = s_big_o; r_ssmall = s_small_o; r_swap = swap_o; r_eq = eq_o;
    r_special = special_o; r_exp = exp_o; r_ma = ma_o; r_mb = mb_o;
  endtask

  task automatic test_reset;
    #2;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if ({exp_o, ma_o, mb_o, special_o, swap_o} !== '0) begin failures++; $display("[TB] FAIL reset_data got %h/%h/%h exp 0", exp_o, ma_o, mb_o); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add_equal;
    run_op(32'h3F800000, 32'h3F800000, 1'b0);
    checks++; if (r_cycles !== 1) begin failures++; $display("[TB] FAIL latency got %0d exp 1", r_cycles); end
    checks++; if (r_exp !== 8'h7F) begin failures++; $display("[TB] FAIL eq_exp got %h exp 7f", r_exp); end
    checks++; if (r_ma !== 28'h4000000 || r_mb !== 28'h4000000) begin failures++; $display("[TB] FAIL eq_mant got %h/%h exp 4000000/4000000", r_ma, r_mb); end
    checks++; if ({r_eq, r_swap, r_sbig, r_ssmall, r_special} !== 5'b10000) begin failures++; $display("[TB] FAIL eq_flags got %b exp 10000", {r_eq, r_swap, r_sbig, r_ssmall, r_special}); end
  endtask

  task automatic test_sub;
    run_op(32'h40000000, 32'h3F800000, 1'b1);
    checks++; if (r_exp !== 8'h80) begin failures++; $display("[TB] FAIL sub_exp got %h exp 80", r_exp); end
    checks++; if (r_ma !== 28'h4000000 || r_mb !== 28'h2000000) begin failures++; $display("[TB] FAIL sub_mant got %h/%h exp 4000000/2000000", r_ma, r_mb); end
    checks++; if ({r_sbig, r_ssmall, r_swap, r_eq} !== 4'b0100) begin failures++; $display("[TB] FAIL sub_flags got %b exp 0100", {r_sbig, r_ssmall, r_swap, r_eq}); end
  endtask

  task automatic test_swap;
    run_op(32'h3F800000, 32'hC0400000, 1'b0);
    checks++; if (r_exp !== 8'h80) begin failures++; $display("[TB] FAIL swap_exp got %h exp 80", r_exp); end
    checks++; if (r_ma !== 28'h6000000 || r_mb !== 28'h2000000) begin failures++; $display("[TB] FAIL swap_mant got %h/%h exp 6000000/2000000", r_ma, r_mb); end
    checks++; if ({r_sbig, r_ssmall, r_swap, r_eq} !== 4'b1010) begin failures++; $display("[TB] FAIL swap_flags got %b exp 1010", {r_sbig, r_ssmall, r_swap, r_eq}); end
  endtask

  task automatic test_sticky;
    run_op(32'h3F800000, 32'h33800001, 1'b0);
    checks++; if (r_mb !== 28'h0000005) begin failures++; $display("[TB] FAIL sticky_d24 got %h exp 0000005", r_mb); end
    run_op(32'h3F800000, 32'h00800000, 1'b0);
    checks++; if (r_mb !== 28'h0000001) begin failures++; $display("[TB] FAIL sticky_far got %h exp 0000001", r_mb); end
    run_op(32'h3F800000, 32'h33000000, 1'b0);
    checks++; if (r_mb !== 28'h0000002) begin failures++; $display("[TB] FAIL shift_d25 got %h exp 0000002", r_mb); end
    run_op(32'h3F800000, 32'h33000001, 1'b0);
    checks++; if (r_mb !== 28'h0000003) begin failures++; $display("[TB] FAIL sticky_d25 got %h exp 0000003", r_mb); end
  endtask

  task automatic test_subnormal;
    logic        e_swap, e_eq;
    logic [27:0] e_ma, e_mb;
`ifdef FP_ALIGN_DAZ_EN
    e_swap = 1'b0; e_eq = 1'b1; e_ma = 28'h0; e_mb = 28'h0;
`else
    e_swap = 1'b1; e_eq = 1'b0; e_ma = 28'h0000010; e_mb = 28'h0000008;
`endif
    run_op(32'h00000001, 32'h00000002, 1'b0);
    checks++; if (r_exp !== 8'h01) begin failures++; $display("[TB] FAIL subn_exp got %h exp 01", r_exp); end
    checks++; if (r_ma !== e_ma || r_mb !== e_mb) begin failures++; $display("[TB] FAIL subn_mant got %h/%h exp %h/%h", r_ma, r_mb, e_ma, e_mb); end
    checks++; if (r_swap !== e_swap || r_eq !== e_eq) begin failures++; $display("[TB] FAIL subn_flags got %b%b exp %b%b", r_swap, r_eq, e_swap, e_eq); end
  endtask

  task automatic test_special;
    run_op(32'h7F800000, 32'h3F800000, 1'b0);
    checks++; if (r_special !== 1'b1) begin failures++; $display("[TB] FAIL special_flag got %b exp 1", r_special); end
    checks++; if (r_exp !== 8'hFF || r_ma !== 28'h0 || r_mb !== 28'h0) begin failures++; $display("[TB] FAIL special_data got %h/%h/%h exp ff/0/0", r_exp, r_ma, r_mb); end
    checks++; if (r_swap !== 1'b0 || r_sbig !== 1'b0) begin failures++; $display("[TB] FAIL special_order got %b%b exp 00", r_swap, r_sbig); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] av [3];
    logic [31:0] bv [3];
    logic        sv [3];
    logic [7:0]  e_exp [3];
    logic [27:0] e_mb [3];
    logic [7:0]  g_exp [3];
    logic [27:0] g_mb [3];
    int acc, got, cyc;
    logic rdy, ov;
    av = '{32'h3F800000, 32'h40000000, 32'h40800000};
    bv = '{32'h3F800000, 32'h3F800000, 32'h3F800000};
    sv = '{1'b0, 1'b1, 1'b0};
    e_exp = '{8'h7F, 8'h80, 8'h81};
    e_mb  = '{28'h4000000, 28'h2000000, 28'h1000000};
    acc = 0; got = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      a_i = av[acc]; b_i = bv[acc]; sub_i = sv[acc]; in_valid = 1'b1;
      rdy = in_ready;
      @(posedge clk); #1;
      if (rdy) acc++;
    end
    checks++; if (acc !== 2) begin failures++; $display("[TB] FAIL stall_accepted got %0d exp 2", acc); end
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin failures++; $display("[TB] FAIL stall_handshake got rdy=%b vld=%b exp rdy=0 vld=1", in_ready, out_valid); end
    checks++; if (exp_o !== 8'h7F || mb_o !== 28'h4000000) begin failures++; $display("[TB] FAIL stall_hold got %h/%h exp 7f/4000000", exp_o, mb_o); end
    out_ready = 1'b1;
    #1;
    cyc = 0;
    while (got < 3 && cyc < 20) begin
      if (acc < 3) begin
        a_i = av[acc]; b_i = bv[acc]; sub_i = sv[acc]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      rdy = in_ready && in_valid;
      ov = out_valid;
      if (ov) begin g_exp[got] = exp_o; g_mb[got] = mb_o; end
      @(posedge clk); #1;
      cyc++;
      if (ov) got++;
      if (rdy) acc++;
    end
    in_valid = 1'b0;
    checks++; if (got !== 3) begin failures++; $display("[TB] FAIL drain_count got %0d exp 3", got); end
    for (int k = 0; k < 3; k++) begin
      if (k < got) begin
        checks++;
        if (g_exp[k] !== e_exp[k] || g_mb[k] !== e_mb[k]) begin
          failures++; $display("[TB] FAIL drain_order[%0d] got %h/%h exp %h/%h", k, g_exp[k], g_mb[k], e_exp[k], e_mb[k]);
        end
      end
    end
  endtask

  task automatic test_reset_midstream;
    int cyc, seen;
    out_ready = 1'b0;
    a_i = 32'h40000000; b_i = 32'h3F800000; sub_i = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 10) begin @(posedge clk); #1; cyc++; end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL midrst_pre got %b exp 1", out_valid); end
    #2; rst_n = 1'b0; #1;
    checks++; if (out_valid !== 1'b0 || exp_o !== 8'h00 || mb_o !== 28'h0) begin failures++; $display("[TB] FAIL midrst_async got vld=%b exp=%h mb=%h exp 0/00/0", out_valid, exp_o, mb_o); end
    @(negedge clk); rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 4; c++) begin @(posedge clk); #1; if (out_valid) seen++; end
    checks++; if (seen !== 0) begin failures++; $display("[TB] FAIL midrst_ghost got %0d results exp 0", seen); end
  endtask

  initial begin
    test_reset;
    test_add_equal;
    test_sub;
    test_swap;
    test_sticky;
    test_subnormal;
    test_special;
    @(posedge clk); #1;
    test_back_to_back;
    @(posedge clk); #1;
    test_reset_midstream;
    test_special;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
